mult_sched: RTL and testbench
=============================

MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter MUL_LAT, default 4: cycles from operands on mul_a/mul_b to the matching product on mul_result; legal range 1..32.
REQ-002 Parameter OPW, default 256: operand width.
REQ-003 Parameter RESW, default 512: product width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req0_valid / req1_valid  input  1  requester 0/1 has an operand pair.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  OPW  operands for requester 0/1.
REQ-008 req0_ready / req1_ready  output  1  grant; the transfer occurs when valid and ready are both high at the clock edge.
REQ-009 mul_a, mul_b  output  OPW  registered operands to the shared multiplier.
REQ-010 mul_result  input  RESW  multiplier product.
REQ-011 rsp0_valid / rsp1_valid  output  1  one-cycle pulse with the product for requester 0/1.
REQ-012 rsp0_data / rsp1_data  output  RESW  registered product for requester 0/1.
REQ-013 inflight  output  6  number of accepted requests not yet answered.

Function
REQ-014 The block SHALL accept at most one request per cycle; ready SHALL be combinational from valid and the priority pointer; at most one of req0_ready/req1_ready SHALL be high.
REQ-015 Arbitration SHALL be round-robin:
- a single valid requester is granted;
- when both are valid, the requester named by pointer prio is granted;
- after any transfer, prio SHALL point to the other requester;
- with no transfer, prio SHALL hold.
REQ-016 A request accepted at edge T SHALL have its operands on mul_a/mul_b during cycle T+1; with no transfer, mul_a/mul_b SHALL hold their previous values.
REQ-017 A tag shift register of depth MUL_LAT+1 (valid bit plus requester-id bit) SHALL advance every cycle; the tag enters on acceptance.
REQ-018 The tag for a request accepted at edge T SHALL emerge during cycle T+1+MUL_LAT. At edge T+1+MUL_LAT, mul_result SHALL be registered into rspN_data and rspN_valid set for exactly one cycle.
- Handshake-to-response latency SHALL be MUL_LAT+2 cycles.
REQ-019 Responses SHALL return in acceptance order; there is no response backpressure.
REQ-020 Sustained throughput SHALL be one request per cycle, alternating between requesters when both are continuously valid.
REQ-021 rspN_data of the requester not pulsed SHALL hold its previous value.
REQ-022 inflight SHALL change by +1 on acceptance and -1 on response, and by 0 when both occur in the same cycle; it SHALL never exceed MUL_LAT+1.
REQ-023 Operands SHALL be passed unmodified; the block performs no arithmetic on data.
REQ-024 A requester deasserting valid without a handshake SHALL not alter prio or the tag pipeline.

Reset
REQ-025 While reset is low, these outputs SHALL be 0: req0_ready, req1_ready, mul_a, mul_b, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, inflight. prio SHALL be 0 and all tag valid bits SHALL be cleared.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight tags; products arriving after reset release SHALL produce no rsp pulse.
REQ-027 The first acceptance SHALL occur no earlier than the first rising edge after reset deasserts.

Verification (MUL_LAT=4, multiplier model = registered product delayed 4 cycles)
REQ-028 Only req0 valid with a=3, b=5, accepted at edge 10 -> mul_a=3 and mul_b=5 in cycle 11; rsp0_valid pulse in cycle 16 with rsp0_data=15; rsp1_valid stays 0.
REQ-029 Both valid every cycle for 6 cycles after reset -> grants in order 0,1,0,1,0,1; six responses 6 cycles after their grants in the same order; inflight peaks at 5.
REQ-030 req1 valid alone for 3 cycles, then both valid -> req1 granted 3 times, then req0 granted first (prio=0 after the last req1 grant).
REQ-031 Reset pulsed low with 3 requests in flight -> no rsp pulses follow, inflight=0, and a new request after release returns its correct product.
REQ-032 Operands a=2^256-1, b=2^256-1 -> rsp_data=2^512-2^257+1, with no truncation.
REQ-033 Acceptance and response in the same cycle -> inflight unchanged.

Source files
------------

// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler that shares one pipelined multiplier
// between two requesters.
//
// Requests are granted combinationally, one per cycle. A granted operand pair
// is registered onto mul_a/mul_b. A tag (valid + requester id) travels down a
// MUL_LAT+1 deep shift register alongside the multiplier. When the tag reaches
// the last stage, mul_result is registered into that requester's response.
//
// Parameters
//   MUL_LAT  multiplier latency in cycles from mul_a/mul_b to mul_result (1..32)
//   OPW      operand width
//   RESW     product width
//
// Ports
//   clk                   clock, rising edge
//   reset                 asynchronous reset, active low
//   req0_valid/req1_valid requester has an operand pair
//   req0_a/b, req1_a/b    operands
//   req0_ready/req1_ready grant (combinational)
//   mul_a, mul_b          registered operands to the shared multiplier
//   mul_result            product from the multiplier
//   rsp0_valid/rsp1_valid one-cycle response pulse
//   rsp0_data/rsp1_data   registered product, held between pulses
//   inflight              accepted requests not yet answered
module mult_sched #(
   parameter int MUL_LAT = 4,
   parameter int OPW     = 256,
   parameter int RESW    = 512
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   input  logic [OPW-1:0]  req0_a,
   input  logic [OPW-1:0]  req0_b,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [OPW-1:0]  req1_a,
   input  logic [OPW-1:0]  req1_b,
   output logic            req1_ready,
   output logic [OPW-1:0]  mul_a,
   output logic [OPW-1:0]  mul_b,
   input  logic [RESW-1:0] mul_result,
   output logic            rsp0_valid,
   output logic [RESW-1:0] rsp0_data,
   output logic            rsp1_valid,
   output logic [RESW-1:0] rsp1_data,
   output logic [5:0]      inflight
);

   logic             prio;      // requester favoured when both are valid
   logic             gnt0;
   logic             gnt1;
   logic             accept;
   logic             retire;
   logic [MUL_LAT:0] tag_vld_p; // bit 0 is the newest tag
   logic [MUL_LAT:0] tag_id_p;

   // Arbitration: ready is held low while reset is asserted so that nothing
   // can be accepted before the first edge after release.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset) begin
         if (req0_valid && (!req1_valid || !prio))
            gnt0 = 1'b1;
         else if (req1_valid)
            gnt1 = 1'b1;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign accept     = gnt0 | gnt1;
   assign retire     = tag_vld_p[MUL_LAT];

   // Pointer moves to the other requester only on a transfer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prio <= 1'b0;
      else if (gnt0)
         prio <= 1'b1;
      else if (gnt1)
         prio <= 1'b0;
   end

   // Stage p0: operand register feeding the multiplier.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_a <= '0;
         mul_b <= '0;
      end else if (accept) begin
         mul_a <= gnt0 ? req0_a : req1_a;
         mul_b <= gnt0 ? req0_b : req1_b;
      end
   end

   // Tag pipeline: advances every cycle so it stays aligned with the
   // multiplier. Only the valid bits need clearing; a stale id is ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         tag_vld_p <= '0;
      else
         tag_vld_p <= {tag_vld_p[MUL_LAT-1:0], accept};
   end

   always_ff @(posedge clk) begin
      tag_id_p <= {tag_id_p[MUL_LAT-1:0], gnt1};
   end

   // Response stage: capture the product when its tag reaches the end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_data  <= '0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         if (retire) begin
            if (tag_id_p[MUL_LAT]) begin
               rsp1_valid <= 1'b1;
               rsp1_data  <= mul_result;
            end else begin
               rsp0_valid <= 1'b1;
               rsp0_data  <= mul_result;
            end
         end
      end
   end

   // Occupancy: bounded by the number of tag stages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         inflight <= '0;
      else begin
         case ({accept, retire})
            2'b10:   inflight <= inflight + 6'd1;
            2'b01:   inflight <= inflight - 6'd1;
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_sched.sv
module tb_mult_sched;

   localparam int MUL_LAT = 4;
   localparam int OPW     = 256;
   localparam int RESW    = 512;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            req0_valid = 1'b0;
   logic [OPW-1:0]  req0_a = '0;
   logic [OPW-1:0]  req0_b = '0;
   logic            req0_ready;
   logic            req1_valid = 1'b0;
   logic [OPW-1:0]  req1_a = '0;
   logic [OPW-1:0]  req1_b = '0;
   logic            req1_ready;
   logic [OPW-1:0]  mul_a;
   logic [OPW-1:0]  mul_b;
   logic [RESW-1:0] mul_result;
   logic            rsp0_valid;
   logic [RESW-1:0] rsp0_data;
   logic            rsp1_valid;
   logic [RESW-1:0] rsp1_data;
   logic [5:0]      inflight;

   int tests = 0;
   int fails = 0;
   int ecount = 0;

   always #5 clk = ~clk;
   always @(posedge clk) ecount <= ecount + 1;

   mult_sched #(.MUL_LAT(MUL_LAT), .OPW(OPW), .RESW(RESW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
      .inflight(inflight)
   );

   // Multiplier model: registered product delayed MUL_LAT cycles.
   logic [RESW-1:0] mp [MUL_LAT];
   always @(posedge clk) begin
      mp[0] <= RESW'(mul_a) * RESW'(mul_b);
      for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
   end
   assign mul_result = mp[MUL_LAT-1];

   task automatic chk(input string nm, input logic [RESW-1:0] got, input logic [RESW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Scoreboard of accepted requests, checked against response pulses.
   typedef struct {
      logic            id;
      logic [RESW-1:0] prod;
      int              due;
   } sb_t;
   sb_t sbq[$];
   sb_t e_mon;
   sb_t e_new;
   logic [RESW-1:0] ed0 = '0;
   logic [RESW-1:0] ed1 = '0;

   always @(negedge clk) begin
      if (!reset) begin
         sbq.delete();
         ed0 = '0;
         ed1 = '0;
      end else begin
         if (rsp0_valid || rsp1_valid) begin
            tests++;
            if (rsp0_valid && rsp1_valid) begin
               fails++;
               $display("FAIL rsp_both: both response pulses high at edge %0d", ecount);
            end else if (sbq.size() == 0) begin
               fails++;
               $display("FAIL rsp_spurious: pulse rsp%0d at edge %0d with nothing in flight", rsp1_valid, ecount);
            end else begin
               tests--;
               e_mon = sbq.pop_front();
               chk("rsp_due_edge", RESW'(ecount), RESW'(e_mon.due));
               chk("rsp_id", RESW'(rsp1_valid), RESW'(e_mon.id));
               if (e_mon.id) ed1 = e_mon.prod;
               else          ed0 = e_mon.prod;
            end
         end else if (sbq.size() > 0) begin
            tests++;
            if (sbq[0].due <= ecount) begin
               fails++;
               $display("FAIL rsp_missing: got no pulse at edge %0d, required one at edge %0d", ecount, sbq[0].due);
               void'(sbq.pop_front());
            end
         end
         chk("rsp0_data", rsp0_data, ed0);
         chk("rsp1_data", rsp1_data, ed1);
         chk("inflight_model", RESW'(inflight), RESW'(sbq.size()));
         if (req0_valid && req0_ready) begin
            e_new.id = 1'b0; e_new.prod = RESW'(req0_a) * RESW'(req0_b); e_new.due = ecount + MUL_LAT + 2;
            sbq.push_back(e_new);
         end
         if (req1_valid && req1_ready) begin
            e_new.id = 1'b1; e_new.prod = RESW'(req1_a) * RESW'(req1_b); e_new.due = ecount + MUL_LAT + 2;
            sbq.push_back(e_new);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic       v0;
      logic       v1;
      logic [7:0] a0;
      logic [7:0] b0;
      logic [7:0] a1;
      logic [7:0] b1;
      logic       er0;
      logic       er1;
      logic [5:0] einf;
   } vec_t;
   vec_t vt [15];

   task automatic send(input logic id, input logic [OPW-1:0] a, input logic [OPW-1:0] b, output int acc);
      @(posedge clk); #1;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      @(posedge clk); #1;
      acc = ecount;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(input logic id, input int maxc, output logic [RESW-1:0] d, output int at);
      logic got;
      got = 1'b0;
      d = '0;
      at = -1;
      for (int i = 0; i < maxc && !got; i++) begin
         @(negedge clk);
         if (id ? rsp1_valid : rsp0_valid) begin
            d = id ? rsp1_data : rsp0_data;
            at = ecount + 1;
            got = 1'b1;
         end
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL rsp_timeout: no pulse from requester %0d within %0d cycles", id, maxc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready0"}, RESW'(req0_ready), '0);
      chk({tag, "_ready1"}, RESW'(req1_ready), '0);
      chk({tag, "_mul_a"}, RESW'(mul_a), '0);
      chk({tag, "_mul_b"}, RESW'(mul_b), '0);
      chk({tag, "_rsp0_valid"}, RESW'(rsp0_valid), '0);
      chk({tag, "_rsp1_valid"}, RESW'(rsp1_valid), '0);
      chk({tag, "_rsp0_data"}, rsp0_data, '0);
      chk({tag, "_rsp1_data"}, rsp1_data, '0);
      chk({tag, "_inflight"}, RESW'(inflight), '0);
   endtask

   int acc;
   int at;
   logic [RESW-1:0] d;
   logic [OPW-1:0]  ema;
   logic [OPW-1:0]  emb;
   logic [RESW-1:0] max_prod;

   initial begin
      //           v0 v1  a0     b0     a1     b1    r0 r1 inflight
      vt[0]  = {2'b11, 8'd2,  8'd3,  8'd4,  8'd5,  2'b10, 6'd1};
      vt[1]  = {2'b11, 8'd6,  8'd7,  8'd8,  8'd9,  2'b01, 6'd2};
      vt[2]  = {2'b11, 8'd10, 8'd11, 8'd12, 8'd13, 2'b10, 6'd3};
      vt[3]  = {2'b11, 8'd14, 8'd15, 8'd16, 8'd17, 2'b01, 6'd4};
      vt[4]  = {2'b11, 8'd18, 8'd19, 8'd20, 8'd21, 2'b10, 6'd5};
      vt[5]  = {2'b11, 8'd22, 8'd23, 8'd24, 8'd25, 2'b01, 6'd5};
      vt[6]  = {2'b00, 8'd26, 8'd27, 8'd28, 8'd29, 2'b00, 6'd4};
      vt[7]  = {2'b01, 8'd30, 8'd31, 8'd32, 8'd33, 2'b01, 6'd4};
      vt[8]  = {2'b01, 8'd34, 8'd35, 8'd36, 8'd37, 2'b01, 6'd4};
      vt[9]  = {2'b01, 8'd38, 8'd39, 8'd40, 8'd41, 2'b01, 6'd4};
      vt[10] = {2'b11, 8'd42, 8'd43, 8'd44, 8'd45, 2'b10, 6'd4};
      vt[11] = {2'b11, 8'd46, 8'd47, 8'd48, 8'd49, 2'b01, 6'd5};
      vt[12] = {2'b10, 8'd50, 8'd51, 8'd52, 8'd53, 2'b10, 6'd5};
      vt[13] = {2'b00, 8'd54, 8'd55, 8'd56, 8'd57, 2'b00, 6'd4};
      vt[14] = {2'b11, 8'd58, 8'd59, 8'd60, 8'd61, 2'b01, 6'd4};

      // Reset state with both requesters asserting valid.
      #1 reset = 1'b0;
      req0_valid = 1'b1; req0_a = 256'd9; req0_b = 256'd9;
      req1_valid = 1'b1; req1_a = 256'd8; req1_b = 256'd8;
      repeat (2) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      repeat (8) @(posedge clk);

      // Single requester 0: 3 * 5.
      send(1'b0, 256'd3, 256'd5, acc);
      chk("single_mul_a", RESW'(mul_a), RESW'(3));
      chk("single_mul_b", RESW'(mul_b), RESW'(5));
      wait_rsp(1'b0, 12, d, at);
      chk("single_data", d, RESW'(15));
      chk("single_latency", RESW'(at - acc), RESW'(MUL_LAT + 2));
      repeat (4) @(posedge clk);

      // Full-width operands.
      max_prod = {{255{1'b1}}, {256{1'b0}}, 1'b1};
      send(1'b1, {OPW{1'b1}}, {OPW{1'b1}}, acc);
      wait_rsp(1'b1, 12, d, at);
      chk("max_operand_data", d, max_prod);
      repeat (4) @(posedge clk);

      // Fresh reset so the pointer starts at requester 0 for the table.
      #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      ema = '0;
      emb = '0;
      @(posedge clk); #1;
      for (int i = 0; i < 15; i++) begin
         req0_valid = vt[i].v0; req0_a = OPW'(vt[i].a0); req0_b = OPW'(vt[i].b0);
         req1_valid = vt[i].v1; req1_a = OPW'(vt[i].a1); req1_b = OPW'(vt[i].b1);
         #3;
         chk($sformatf("row%0d_ready0", i), RESW'(req0_ready), RESW'(vt[i].er0));
         chk($sformatf("row%0d_ready1", i), RESW'(req1_ready), RESW'(vt[i].er1));
         if (vt[i].er0) begin ema = OPW'(vt[i].a0); emb = OPW'(vt[i].b0); end
         else if (vt[i].er1) begin ema = OPW'(vt[i].a1); emb = OPW'(vt[i].b1); end
         @(posedge clk); #1;
         chk($sformatf("row%0d_inflight", i), RESW'(inflight), RESW'(vt[i].einf));
         chk($sformatf("row%0d_mul_a", i), RESW'(mul_a), RESW'(ema));
         chk($sformatf("row%0d_mul_b", i), RESW'(mul_b), RESW'(emb));
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (10) @(posedge clk);

      // Reset with three requests in flight.
      #1;
      req0_valid = 1'b1;
      req0_a = 256'd11; req0_b = 256'd12;
      @(posedge clk); #1 req0_a = 256'd13; req0_b = 256'd14;
      @(posedge clk); #1 req0_a = 256'd15; req0_b = 256'd16;
      @(posedge clk); #1 req0_valid = 1'b0;
      chk("pre_reset_inflight", RESW'(inflight), RESW'(3));
      reset = 1'b0;
      req1_valid = 1'b1;
      #2;
      check_reset_outputs("midreset");
      req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_reset_inflight", RESW'(inflight), '0);
      send(1'b0, 256'd7, 256'd9, acc);
      wait_rsp(1'b0, 12, d, at);
      chk("post_reset_data", d, RESW'(63));
      chk("post_reset_latency", RESW'(at - acc), RESW'(MUL_LAT + 2));
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
